// File: rtl/lc3_control_fsm.sv
// rtl/lc3_control_fsm.sv - multi-cycle LC3 control sequencer
// Moore FSM stepping each instruction through fetch/decode/execute/memory/writeback/PC-update.
module lc3_control_fsm #(
    parameter int ILLEGAL_HALT = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      instr,
    input  logic [2:0]       nzp,
    input  logic             mem_ready,
    output logic [3:0]       state,
    output logic             enable_fetch,
    output logic             enable_decode,
    output logic             enable_execute,
    output logic             enable_writeback,
    output logic             enable_updatepc,
    output logic             br_taken,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH        = 4'h0,
        S_DECODE       = 4'h1,
        S_EXEC_ALU     = 4'h2,
        S_EXEC_NPC     = 4'h3,
        S_EXEC_MEMADDR = 4'h4,
        S_RMEM         = 4'h5,
        S_IRMEM        = 4'h6,
        S_WMEM         = 4'h7,
        S_UPDATE_PC    = 4'h8,
        S_UPDATE_REG   = 4'h9,
        S_INVALID      = 4'hA
    } state_t;

    localparam logic [3:0] OP_BR  = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h2;
    localparam logic [3:0] OP_ST  = 4'h3;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_LDR = 4'h6;
    localparam logic [3:0] OP_STR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h9;
    localparam logic [3:0] OP_LDI = 4'hA;
    localparam logic [3:0] OP_STI = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_LEA = 4'hE;

    state_t           state_q, state_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [2:0]       cond_q, cond_d;
    logic             br_taken_q, br_taken_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            opcode_q   <= 4'h0;
            cond_q     <= 3'b000;
            br_taken_q <= 1'b0;
            illegal_q  <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            cond_q     <= cond_d;
            br_taken_q <= br_taken_d;
            illegal_q  <= illegal_d;
            retired_q  <= retired_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        cond_d     = cond_q;
        br_taken_d = 1'b0;
        illegal_d  = illegal_q;
        retired_d  = retired_q;
        case (state_q)
            S_FETCH: if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                opcode_d = instr[15:12];
                cond_d   = instr[11:9];
                case (instr[15:12])
                    OP_ADD, OP_AND, OP_NOT:                     state_d = S_EXEC_ALU;
                    OP_LEA, OP_BR, OP_JMP:                      state_d = S_EXEC_NPC;
                    OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI: state_d = S_EXEC_MEMADDR;
                    default:                                    state_d = S_INVALID;
                endcase
            end
            S_EXEC_ALU: state_d = S_UPDATE_REG;
            S_EXEC_NPC: begin
                if (opcode_q == OP_LEA) begin
                    state_d = S_UPDATE_REG;
                end else begin
                    // nzp is sampled here so br_taken is valid for the whole UpdatePC cycle
                    state_d    = S_UPDATE_PC;
                    br_taken_d = (opcode_q == OP_JMP) ||
                                 ((opcode_q == OP_BR) && ((cond_q & nzp) != 3'b000));
                end
            end
            S_EXEC_MEMADDR: begin
                case (opcode_q)
                    OP_LDI, OP_STI: state_d = S_IRMEM;
                    OP_LD, OP_LDR:  state_d = S_RMEM;
                    default:        state_d = S_WMEM;
                endcase
            end
            S_RMEM:  if (mem_ready) state_d = S_UPDATE_REG;
            S_IRMEM: if (mem_ready) state_d = (opcode_q == OP_LDI) ? S_RMEM : S_WMEM;
            S_WMEM:  if (mem_ready) state_d = S_UPDATE_PC;
            S_UPDATE_PC: begin
                state_d   = S_FETCH;
                retired_d = retired_q + CNT_W'(1);
            end
            S_UPDATE_REG: state_d = S_UPDATE_PC;
            S_INVALID: if (ILLEGAL_HALT == 0) state_d = S_UPDATE_PC;
            default: state_d = S_FETCH;
        endcase
        if (state_d == S_INVALID) illegal_d = 1'b1;
    end

    always_comb begin
        enable_fetch     = 1'b0;
        enable_decode    = 1'b0;
        enable_execute   = 1'b0;
        enable_writeback = 1'b0;
        enable_updatepc  = 1'b0;
        mem_rd           = 1'b0;
        mem_wr           = 1'b0;
        case (state_q)
            S_FETCH: begin
                enable_fetch = 1'b1;
                mem_rd       = 1'b1;
            end
            S_DECODE:                               enable_decode    = 1'b1;
            S_EXEC_ALU, S_EXEC_NPC, S_EXEC_MEMADDR: enable_execute   = 1'b1;
            S_RMEM, S_IRMEM:                        mem_rd           = 1'b1;
            S_WMEM:                                 mem_wr           = 1'b1;
            S_UPDATE_REG:                           enable_writeback = 1'b1;
            S_UPDATE_PC:                            enable_updatepc  = 1'b1;
            default: ;
        endcase
    end

    assign state    = state_q;
    assign br_taken = br_taken_q;
    assign illegal  = illegal_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// tb/tb_lc3_control_fsm.sv - self-checking bench for lc3_control_fsm
// Two instances: halting with 16-bit counter, and NOP-retiring with 4-bit counter.
module tb_lc3_control_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = 16'h0;
    logic [2:0]  nzp = 3'b000;
    logic        mem_ready = 1'b1;

    logic [3:0]  st_h, st_n;
    logic        ef_h, ed_h, ee_h, ew_h, eu_h, br_h, rd_h, wr_h, ill_h;
    logic        ef_n, ed_n, ee_n, ew_n, eu_n, br_n, rd_n, wr_n, ill_n;
    logic [15:0] ret_h;
    logic [3:0]  ret_n;
    logic [6:0]  en_h, en_n;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lc3_control_fsm #(.ILLEGAL_HALT(1), .CNT_W(16)) dut_h (
        .clk(clk), .rst(rst), .instr(instr), .nzp(nzp), .mem_ready(mem_ready),
        .state(st_h), .enable_fetch(ef_h), .enable_decode(ed_h), .enable_execute(ee_h),
        .enable_writeback(ew_h), .enable_updatepc(eu_h), .br_taken(br_h),
        .mem_rd(rd_h), .mem_wr(wr_h), .illegal(ill_h), .retired(ret_h)
    );

    lc3_control_fsm #(.ILLEGAL_HALT(0), .CNT_W(4)) dut_n (
        .clk(clk), .rst(rst), .instr(instr), .nzp(nzp), .mem_ready(mem_ready),
        .state(st_n), .enable_fetch(ef_n), .enable_decode(ed_n), .enable_execute(ee_n),
        .enable_writeback(ew_n), .enable_updatepc(eu_n), .br_taken(br_n),
        .mem_rd(rd_n), .mem_wr(wr_n), .illegal(ill_n), .retired(ret_n)
    );

    assign en_h = {ef_h, ed_h, ee_h, ew_h, eu_h, rd_h, wr_h};
    assign en_n = {ef_n, ed_n, ee_n, ew_n, eu_n, rd_n, wr_n};

    typedef struct {
        logic        rst;
        logic [15:0] instr;
        logic [2:0]  nzp;
        logic        mr;
        logic [3:0]  st;
        logic        br;
        logic        wb;
        logic        rd;
        logic        wr;
        logic [15:0] ret;
    } vec_t;

    vec_t vecs[20];

    logic [3:0]  m_cur[2];
    logic [23:0] m_rte[2];
    logic [3:0]  m_op[2];
    logic [2:0]  m_cond[2];
    logic        m_br[2];
    logic        m_ill[2];
    int unsigned m_ret[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Post-Decode state sequence per opcode, one nibble per state, read from the top.
    function automatic logic [23:0] route_of(input logic [3:0] op);
        case (op)
            4'h1, 4'h5, 4'h9: return 24'h298000;
            4'hE:             return 24'h398000;
            4'h0, 4'hC:       return 24'h380000;
            4'h2, 4'h6:       return 24'h459800;
            4'hA:             return 24'h465980;
            4'h3, 4'h7:       return 24'h478000;
            4'hB:             return 24'h467800;
            default:          return 24'hA80000;
        endcase
    endfunction

    // {fetch, decode, execute, writeback, updatepc, mem_rd, mem_wr}
    function automatic logic [6:0] exp_en(input logic [3:0] s);
        case (s)
            4'h0:             return 7'b1000010;
            4'h1:             return 7'b0100000;
            4'h2, 4'h3, 4'h4: return 7'b0010000;
            4'h5, 4'h6:       return 7'b0000010;
            4'h7:             return 7'b0000001;
            4'h8:             return 7'b0000100;
            4'h9:             return 7'b0001000;
            default:          return 7'b0000000;
        endcase
    endfunction

    task automatic model_step(input int k);
        logic nbr;
        nbr = 1'b0;
        if (rst) begin
            m_cur[k] = 4'h0; m_rte[k] = '0; m_op[k] = 4'h0; m_cond[k] = 3'b0;
            m_ret[k] = 0; m_ill[k] = 1'b0;
        end else if ((m_cur[k] == 4'h0 || m_cur[k] == 4'h5 || m_cur[k] == 4'h6 ||
                      m_cur[k] == 4'h7) && !mem_ready) begin
            m_cur[k] = m_cur[k];
        end else begin
            case (m_cur[k])
                4'h0: m_cur[k] = 4'h1;
                4'h1: begin
                    m_op[k]   = instr[15:12];
                    m_cond[k] = instr[11:9];
                    m_rte[k]  = route_of(instr[15:12]);
                    m_cur[k]  = m_rte[k][23:20];
                    m_rte[k]  = m_rte[k] << 4;
                end
                4'h8: begin
                    m_ret[k]++;
                    m_cur[k] = 4'h0;
                end
                4'hA: if (k == 1) m_cur[k] = 4'h8;
                default: begin
                    if (m_cur[k] == 4'h3)
                        nbr = (m_op[k] == 4'hC) || (m_op[k] == 4'h0 && (m_cond[k] & nzp) != 0);
                    m_cur[k] = m_rte[k][23:20];
                    m_rte[k] = m_rte[k] << 4;
                end
            endcase
            if (m_cur[k] == 4'hA) m_ill[k] = 1'b1;
        end
        m_br[k] = nbr;
    endtask

    task automatic compare_model(input int k);
        check($sformatf("rnd_state%0d", k), k ? st_n : st_h, m_cur[k]);
        check($sformatf("rnd_en%0d", k), k ? en_n : en_h, exp_en(m_cur[k]));
        check($sformatf("rnd_br%0d", k), k ? br_n : br_h, m_br[k]);
        check($sformatf("rnd_ill%0d", k), k ? ill_n : ill_h, m_ill[k]);
        check($sformatf("rnd_ret%0d", k), k ? ret_n : ret_h,
              k ? (m_ret[k] & 32'hF) : (m_ret[k] & 32'hFFFF));
    endtask

    initial begin
        int          cyc, waits;
        bit          left, rd_bad, found;
        logic [3:0]  prev;
        logic [15:0] ret_h0;
        logic [3:0]  ret_n0;

        //        rst  instr     nzp     mr  st    br  wb  rd  wr  ret
        vecs[0]  = '{1, 16'h1261, 3'b000, 1, 4'h0, 0, 0, 1, 0, 16'd0};
        vecs[1]  = '{0, 16'h1261, 3'b000, 1, 4'h1, 0, 0, 0, 0, 16'd0};
        vecs[2]  = '{0, 16'h1261, 3'b000, 1, 4'h2, 0, 0, 0, 0, 16'd0};
        vecs[3]  = '{0, 16'h1261, 3'b000, 1, 4'h9, 0, 1, 0, 0, 16'd0};
        vecs[4]  = '{0, 16'h1261, 3'b000, 1, 4'h8, 0, 0, 0, 0, 16'd0};
        vecs[5]  = '{0, 16'h1261, 3'b000, 1, 4'h0, 0, 0, 1, 0, 16'd1};
        vecs[6]  = '{0, 16'h0405, 3'b010, 1, 4'h1, 0, 0, 0, 0, 16'd1};
        vecs[7]  = '{0, 16'h0405, 3'b010, 1, 4'h3, 0, 0, 0, 0, 16'd1};
        vecs[8]  = '{0, 16'h0405, 3'b010, 1, 4'h8, 1, 0, 0, 0, 16'd1};
        vecs[9]  = '{0, 16'h0405, 3'b010, 1, 4'h0, 0, 0, 1, 0, 16'd2};
        vecs[10] = '{0, 16'h0405, 3'b001, 1, 4'h1, 0, 0, 0, 0, 16'd2};
        vecs[11] = '{0, 16'h0405, 3'b001, 1, 4'h3, 0, 0, 0, 0, 16'd2};
        vecs[12] = '{0, 16'h0405, 3'b001, 1, 4'h8, 0, 0, 0, 0, 16'd2};
        vecs[13] = '{0, 16'h0405, 3'b001, 1, 4'h0, 0, 0, 1, 0, 16'd3};
        vecs[14] = '{0, 16'hB002, 3'b000, 1, 4'h1, 0, 0, 0, 0, 16'd3};
        vecs[15] = '{0, 16'hB002, 3'b000, 1, 4'h4, 0, 0, 0, 0, 16'd3};
        vecs[16] = '{0, 16'hB002, 3'b000, 1, 4'h6, 0, 0, 1, 0, 16'd3};
        vecs[17] = '{0, 16'hB002, 3'b000, 1, 4'h7, 0, 0, 0, 1, 16'd3};
        vecs[18] = '{0, 16'hB002, 3'b000, 1, 4'h8, 0, 0, 0, 0, 16'd3};
        vecs[19] = '{0, 16'hB002, 3'b000, 1, 4'h0, 0, 0, 1, 0, 16'd4};

        for (int i = 0; i < 20; i++) begin
            rst = vecs[i].rst; instr = vecs[i].instr; nzp = vecs[i].nzp; mem_ready = vecs[i].mr;
            tick();
            check($sformatf("vec%0d_state", i), st_h, vecs[i].st);
            check($sformatf("vec%0d_br", i), br_h, vecs[i].br);
            check($sformatf("vec%0d_wb", i), ew_h, vecs[i].wb);
            check($sformatf("vec%0d_rd", i), rd_h, vecs[i].rd);
            check($sformatf("vec%0d_wr", i), wr_h, vecs[i].wr);
            check($sformatf("vec%0d_ret", i), ret_h, vecs[i].ret);
            if (i == 0) check("reset_illegal", ill_h, 1'b0);
        end

        // LDI with two wait cycles in each memory state
        instr = 16'hA002; cyc = 0; waits = 0; left = 0; rd_bad = 0;
        while (!(left && st_h == 4'h0) && cyc < 40) begin
            if ((st_h == 4'h0 || st_h == 4'h5 || st_h == 4'h6) && !rd_h) rd_bad = 1;
            mem_ready = (st_h == 4'h0 || st_h == 4'h5 || st_h == 4'h6 || st_h == 4'h7) ?
                        (waits >= 2) : 1'b1;
            prev = st_h;
            tick();
            cyc++;
            waits = (st_h == prev) ? waits + 1 : 0;
            if (st_h != 4'h0) left = 1;
        end
        check("ldi_wait_cycles", cyc, 13);
        check("ldi_wait_mem_rd", rd_bad, 1'b0);
        check("ldi_wait_ret", ret_h, 16'd5);
        mem_ready = 1;

        // Illegal opcode on both variants
        instr = 16'hD000;
        tick(); tick();
        check("ill_h_state", st_h, 4'hA);
        check("ill_h_flag", ill_h, 1'b1);
        check("ill_n_state", st_n, 4'hA);
        check("ill_n_flag", ill_n, 1'b1);
        ret_h0 = ret_h; ret_n0 = ret_n;
        instr = 16'h1261;
        tick();
        check("ill_n_to_updpc", st_n, 4'h8);
        check("ill_n_br", br_n, 1'b0);
        tick();
        check("ill_n_to_fetch", st_n, 4'h0);
        check("ill_n_ret", ret_n, ret_n0 + 4'd1);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("halt%0d_state", i), st_h, 4'hA);
            check($sformatf("halt%0d_en", i), {en_h, br_h}, 8'h00);
            check($sformatf("halt%0d_ret", i), ret_h, ret_h0);
            check($sformatf("halt%0d_ill", i), ill_h, 1'b1);
            tick();
        end
        check("ill_n_sticky", ill_n, 1'b1);

        // Reset while stalled in RMem
        instr = 16'h2000; found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (st_n == 4'h5) found = 1;
        end
        check("rmid_reached_rmem", found, 1'b1);
        mem_ready = 0;
        tick();
        check("rmid_stall", st_n, 4'h5);
        rst = 1;
        tick();
        check("rmid_state", st_n, 4'h0);
        check("rmid_ret", ret_n, 4'd0);
        check("rmid_ill", ill_n, 1'b0);
        check("rmid_rd", rd_n, 1'b1);
        check("rmid_h_state", st_h, 4'h0);
        check("rmid_h_ill", ill_h, 1'b0);
        rst = 0; mem_ready = 1;

        // Counter wrap: 17 ADDs
        instr = 16'h1261;
        repeat (85) tick();
        check("wrap_state", st_h, 4'h0);
        check("wrap_ret_h", ret_h, 16'd17);
        check("wrap_ret_n", ret_n, 4'd1);

        // Randomized run against the behavioural model
        rst = 1;
        model_step(0); model_step(1);
        tick();
        compare_model(0); compare_model(1);
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 59) == 0);
            instr     = 16'($urandom);
            nzp       = 3'($urandom);
            mem_ready = ($urandom_range(0, 9) < 7);
            model_step(0); model_step(1);
            tick();
            compare_model(0); compare_model(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
